// File: rtl/half_adder_pkg.sv
// Shared defaults for the half_adder block: lane count and carry-event counter width.
package half_adder_pkg;

   localparam int unsigned HA_WIDTH_DEF = 32'd1;
   localparam int unsigned HA_CNT_W_DEF = 32'd16;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// One-bit half adder lane: purely combinational sum and carry.
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Multi-lane half adder with combinational outputs, a registered copy qualified by IN_VALID,
// and a saturating counter of valid cycles that produced any carry.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int unsigned WIDTH = HA_WIDTH_DEF,
   parameter int unsigned CNT_W = HA_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             IN_VALID,
   output logic [WIDTH-1:0] SUM,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] SUM_Q,
   output logic [WIDTH-1:0] COUNT_Q,
   output logic             OUT_VALID,
   output logic [CNT_W-1:0] CARRY_CNT
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] count_s;
   logic             carry_any_s;

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic [WIDTH-1:0] count_d, count_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d,   cnt_q;

   // Lanes are fully independent; no carry chain between them.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
      half_adder_cell u_cell (
         .a (A[i]),
         .b (B[i]),
         .s (sum_s[i]),
         .c (count_s[i])
      );
   end

   assign carry_any_s = |count_s;

   // Next-state for captured result and the saturating carry-event counter.
   always_comb begin
      sum_d   = sum_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      valid_d = IN_VALID;
      if (IN_VALID) begin
         sum_d   = sum_s;
         count_d = count_s;
         if (carry_any_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         sum_d   = sum_q;
         count_d = count_q;
      end
   end

   // State registers; reset wins over any qualified capture in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sum_q   <= sum_d;
         count_q <= count_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign SUM       = sum_s;
   assign COUNT     = count_s;
   assign SUM_Q     = sum_q;
   assign COUNT_Q   = count_q;
   assign OUT_VALID = valid_q;
   assign CARRY_CNT = cnt_q;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Scoreboard bench: a 4-lane/2-bit-counter instance and a 1-lane/16-bit-counter instance share stimulus.
module tb_half_adder;

   logic        clk;
   logic        rst;
   logic        iv;
   logic [3:0]  a4;
   logic [3:0]  b4;

   logic [3:0]  sum4, count4, sumq4, countq4;
   logic        ov4;
   logic [1:0]  cc4;
   logic [0:0]  sum1, count1, sumq1, countq1;
   logic        ov1;
   logic [15:0] cc1;

   half_adder #(.WIDTH(4), .CNT_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .A(a4), .B(b4), .IN_VALID(iv),
      .SUM(sum4), .COUNT(count4), .SUM_Q(sumq4), .COUNT_Q(countq4),
      .OUT_VALID(ov4), .CARRY_CNT(cc4)
   );

   half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .A(a4[0:0]), .B(b4[0:0]), .IN_VALID(iv),
      .SUM(sum1), .COUNT(count1), .SUM_Q(sumq1), .COUNT_Q(countq1),
      .OUT_VALID(ov1), .CARRY_CNT(cc1)
   );

   typedef struct {
      logic [3:0]  s4, c4, sq4, cq4;
      logic [1:0]  cc4;
      logic        s1, c1, sq1, cq1;
      logic [15:0] cc1;
      logic        ov;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference state, expressed as plain integers.
   int m4_sq = 0, m4_cq = 0, m4_cc = 0;
   int m1_sq = 0, m1_cq = 0, m1_cc = 0;
   int m_ov  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, advance the model across the coming edge, queue the expectation.
   task automatic drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int s4 = 0;
      int c4 = 0;
      int s;
      int s1;
      int c1;
      rst = r; iv = v; a4 = a; b4 = b;
      for (int i = 0; i < 4; i++) begin
         s = int'(a[i]) + int'(b[i]);
         s4 += (s % 2) << i;
         c4 += (s / 2) << i;
      end
      s  = int'(a[0]) + int'(b[0]);
      s1 = s % 2;
      c1 = s / 2;
      if (r) begin
         m4_sq = 0; m4_cq = 0; m4_cc = 0;
         m1_sq = 0; m1_cq = 0; m1_cc = 0;
         m_ov  = 0;
      end else begin
         m_ov = int'(v);
         if (v) begin
            m4_sq = s4; m4_cq = c4;
            m1_sq = s1; m1_cq = c1;
            if (c4 > 0 && m4_cc < 3) m4_cc++;
            if (c1 > 0 && m1_cc < 65535) m1_cc++;
         end
      end
      e.s4  = 4'(s4);    e.c4  = 4'(c4);
      e.sq4 = 4'(m4_sq); e.cq4 = 4'(m4_cq); e.cc4 = 2'(m4_cc);
      e.s1  = 1'(s1);    e.c1  = 1'(c1);
      e.sq1 = 1'(m1_sq); e.cq1 = 1'(m1_cq); e.cc1 = 16'(m1_cc);
      e.ov  = 1'(m_ov);
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every edge presents a result; compare it with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sum4",    32'(sum4),    32'(e.s4));
            check("count4",  32'(count4),  32'(e.c4));
            check("sum_q4",  32'(sumq4),   32'(e.sq4));
            check("cnt_q4",  32'(countq4), 32'(e.cq4));
            check("ovalid4", 32'(ov4),     32'(e.ov));
            check("ccnt4",   32'(cc4),     32'(e.cc4));
            check("sum1",    32'(sum1),    32'(e.s1));
            check("count1",  32'(count1),  32'(e.c1));
            check("sum_q1",  32'(sumq1),   32'(e.sq1));
            check("cnt_q1",  32'(countq1), 32'(e.cq1));
            check("ovalid1", 32'(ov1),     32'(e.ov));
            check("ccnt1",   32'(cc1),     32'(e.cc1));
         end
      end
   end

   initial begin
      int budget;
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      // Truth table on every lane, unqualified so the counter stays at zero.
      drive(1'b0, 1'b0, 4'b0000, 4'b0000);
      drive(1'b0, 1'b0, 4'b1111, 4'b0000);
      drive(1'b0, 1'b0, 4'b0000, 4'b1111);
      drive(1'b0, 1'b0, 4'b1111, 4'b1111);
      // Single valid 1+1, then hold with IN_VALID low.
      drive(1'b0, 1'b1, 4'b0001, 4'b0001);
      drive(1'b0, 1'b0, 4'b0000, 4'b0001);
      drive(1'b0, 1'b0, 4'b0001, 4'b0000);
      // Mixed lanes: 1100 + 1010.
      drive(1'b0, 1'b1, 4'b1100, 4'b1010);
      // Reset mid-stream with a qualifying carry present.
      drive(1'b1, 1'b1, 4'b1111, 4'b1111);
      // Saturation of the 2-bit counter.
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 4'b1111, 4'b1111);
      drive(1'b0, 1'b1, 4'b0000, 4'b0000);
      drive(1'b1, 1'b0, 4'b0000, 4'b0000);
      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               4'($urandom), 4'($urandom));
      end
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_half_adder

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit lanes in A, B, SUM, COUNT, SUM_Q and COUNT_Q.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter CARRY_CNT.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all registered outputs.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A  input  WIDTH  addend A.
REQ-007 B  input  WIDTH  addend B.
REQ-008 IN_VALID  input  1  qualifies A/B for registered capture and counting.
REQ-009 SUM  output  WIDTH  combinational sum, A XOR B per lane.
REQ-010 COUNT  output  WIDTH  combinational carry, A AND B per lane.
REQ-011 SUM_Q  output  WIDTH  registered SUM.
REQ-012 COUNT_Q  output  WIDTH  registered COUNT.
REQ-013 OUT_VALID  output  1  registered IN_VALID.
REQ-014 CARRY_CNT  output  CNT_W  saturating count of valid cycles with any carry.
REQ-015 Instantiations SHALL use named port connections.

Function
REQ-016 SUM[i] SHALL equal A[i] XOR B[i] for every lane i, with zero latency and no dependence on clk, rst or IN_VALID.
REQ-017 COUNT[i] SHALL equal A[i] AND B[i] for every lane i, with zero latency and no dependence on clk, rst or IN_VALID.
REQ-018 Truth table per lane (A,B -> SUM,COUNT): 00->00, 10->10, 01->10, 11->01.
REQ-019 SUM_Q and COUNT_Q SHALL load SUM and COUNT on a rising clk edge when IN_VALID=1 and rst=0, and SHALL hold their value otherwise.
REQ-020 OUT_VALID SHALL equal the IN_VALID value sampled at the previous rising edge, giving a registered latency of exactly 1 cycle.
REQ-021 CARRY_CNT SHALL increment by 1 on a rising edge when IN_VALID=1 and any COUNT bit is 1.
REQ-022 CARRY_CNT SHALL saturate at all-ones: further qualifying events leave it unchanged, with no wrap-around.
REQ-023 Lanes SHALL be independent; no carry propagates between lanes.
REQ-024 X/Z-free inputs SHALL produce X-free outputs; no latches.

Reset
REQ-025 When rst=1 at a rising edge, SUM_Q, COUNT_Q, OUT_VALID and CARRY_CNT SHALL become 0.
REQ-026 rst SHALL take priority over IN_VALID in the same cycle, including reset asserted mid-stream.
REQ-027 SUM and COUNT SHALL remain functional while rst is asserted.
REQ-028 Registered outputs SHALL resume normal operation on the first rising edge after rst deasserts.

Structure
REQ-029 The shared package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants.
REQ-030 A 1-bit combinational sub-module half_adder_cell (a, b -> s, c) SHALL be instantiated once per lane by a generate loop.
REQ-031 The top level SHALL contain only the lane array, the output registers and the counter.

Verification
REQ-032 WIDTH=1, vectors (A,B) = 00, 10, 01, 11, each applied for 5 ns -> (SUM,COUNT) = 00, 10, 10, 01 immediately.
REQ-033 A=1, B=1, IN_VALID=1 for one cycle -> SUM_Q=0, COUNT_Q=1 and OUT_VALID=1 one cycle later; with IN_VALID=0 afterwards, SUM_Q/COUNT_Q hold and OUT_VALID=0.
REQ-034 Reset mid-stream: rst=1 with IN_VALID=1, A=B=1 -> next edge SUM_Q=COUNT_Q=OUT_VALID=CARRY_CNT=0, while SUM=0 and COUNT=1 combinationally.
REQ-035 CNT_W=2, apply 5 valid A=B=1 cycles -> CARRY_CNT sequence 1, 2, 3, 3, 3.
REQ-036 WIDTH=4, A=4'b1100, B=4'b1010 -> SUM=4'b0110, COUNT=4'b1000; one valid cycle increments CARRY_CNT by 1.
